chu_note_seq_core: RTL

- MMIO slot core that sequences the DDFS/ADSR audio datapath autonomously.
- CPU pushes notes (frequency control word plus duration) into an on-chip FIFO.
- The core pops notes at tick-timed intervals, drives the DDFS external frequency word, and issues envelope start/gate to the ADSR core.
- Occupies one user slot on the FPro MMIO bus, using the standard slot interface.

---
 rtl/chu_note_seq_core.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/chu_note_seq_core.sv
// chu_note_seq_core: FPro MMIO slot core that plays queued notes on its own.
// The CPU pushes {focw, duration} notes into a FIFO. The core pops one note at
// a time, drives the DDFS frequency word and fires the ADSR start/gate.
// Optional macro NOTE_SEQ_LOOP_EN: with ctrl bit2 set, each popped note is
// re-pushed to the FIFO tail so the sequence repeats.
// Ports:
//   clk, reset            clock, async active-high reset
//   cs/read/write/addr    slot bus select, strobes, register address
//   wr_data, rd_data      slot write data, read data (combinational on addr)
//   focw_out              frequency control word to DDFS focw_ext
//   env_start             one-cycle ADSR start pulse
//   gate                  high while a note sounds
//   busy                  high when the sequencer is not idle
module chu_note_seq_core #(
  parameter int unsigned FIFO_DEPTH_BIT = 4,
  parameter int unsigned TICK_DIV       = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [25:0] focw_out,
  output logic        env_start,
  output logic        gate,
  output logic        busy
);
  localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_BIT;
  localparam int unsigned CNT_W   = FIFO_DEPTH_BIT + 1;
  localparam int unsigned FOCW_W  = 26;
  localparam int unsigned DUR_W   = 16;
  localparam int unsigned ENTRY_W = FOCW_W + DUR_W;
  localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, GAP = 2'd3} state_t;

  state_t                      state_q, state_d;
  logic [FIFO_DEPTH_BIT-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [ENTRY_W-1:0]          mem_q [DEPTH];
  logic [ENTRY_W-1:0]          mem_wdata, head;
  logic                        mem_we;
  logic [DUR_W-1:0]            dur_stage_q, dur_stage_d, gap_q, gap_d;
  logic [DUR_W-1:0]            dur_cur_q, dur_cur_d, tcnt_q, tcnt_d, tgt;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [FOCW_W-1:0]           focw_q, focw_d;
  logic [31:0]                 played_q, played_d;
  logic run_q, run_d, ovf_q, ovf_d, gate_q, gate_d, env_q, env_d, busy_q, busy_d;
  logic loop_q;
  logic wr_sel, push_req, flush, ovf_clr, pop, repush, empty, full, tick, last_tick;
  logic unused_c;

`ifdef NOTE_SEQ_LOOP_EN
  logic loop_d;
  always_comb begin
    loop_d = loop_q;
    if (wr_sel && addr == 5'd4) loop_d = wr_data[2];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) loop_q <= 1'b0;
    else       loop_q <= loop_d;
  end
`else
  assign loop_q = 1'b0;
`endif

  assign unused_c = &{1'b0, read, wr_data[31:26]};
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign head     = mem_q[rd_ptr_q];

  // Bus register writes and strobes
  always_comb begin
    run_d       = run_q;
    dur_stage_d = dur_stage_q;
    gap_d       = gap_q;
    wr_sel      = cs & write;
    push_req    = wr_sel && (addr == 5'd3);
    flush       = wr_sel && (addr == 5'd4) && wr_data[1];
    ovf_clr     = wr_sel && (addr == 5'd4) && wr_data[3];
    if (wr_sel) begin
      case (addr)
        5'd2:    dur_stage_d = wr_data[15:0];
        5'd4:    run_d       = wr_data[0];
        5'd5:    gap_d       = wr_data[15:0];
        default: ;
      endcase
    end
  end

  // FIFO pointers/count; a loop re-push owns the write port in LOAD, so a
  // CPU push landing in that same cycle is dropped and flagged as overflow.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_wdata = {wr_data[25:0], dur_stage_q};
    repush    = pop & loop_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push_req && (repush || (full && !pop))) ovf_d = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (repush) begin
        mem_we    = 1'b1;
        mem_wdata = head;
      end else if (push_req && (!full || pop)) begin
        mem_we = 1'b1;
      end
      if (mem_we) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_BIT'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + FIFO_DEPTH_BIT'(1);
      count_d = count_q + CNT_W'(mem_we) - CNT_W'(pop);
    end
  end

  // Sequencer next state and registered outputs
  always_comb begin
    state_d   = state_q;
    focw_d    = focw_q;
    gate_d    = gate_q;
    env_d     = 1'b0;
    played_d  = played_q;
    dur_cur_d = dur_cur_q;
    div_d     = div_q;
    tcnt_d    = tcnt_q;
    pop       = 1'b0;
    tick      = (div_q == DIV_W'(TICK_DIV - 1));
    tgt       = (state_q == GAP) ? gap_q : ((dur_cur_q == '0) ? DUR_W'(1) : dur_cur_q);
    last_tick = tick && ((17'(tcnt_q) + 17'd1) >= 17'(tgt));
    case (state_q)
      IDLE: begin
        gate_d = 1'b0;
        if (run_q && !empty) state_d = LOAD;
      end
      LOAD: begin
        // Flush can empty the FIFO on the edge we enter LOAD
        if (!run_q || empty) begin
          state_d = IDLE;
          gate_d  = 1'b0;
        end else begin
          pop       = 1'b1;
          focw_d    = head[ENTRY_W-1:DUR_W];
          dur_cur_d = head[DUR_W-1:0];
          gate_d    = 1'b1;
          env_d     = 1'b1;
          played_d  = played_q + 32'd1;
          div_d     = '0;
          tcnt_d    = '0;
          state_d   = PLAY;
        end
      end
      PLAY, GAP: begin
        if (!run_q) begin
          state_d = IDLE;
          gate_d  = 1'b0;
          div_d   = '0;
          tcnt_d  = '0;
        end else begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
          if (last_tick) begin
            tcnt_d = '0;
            gate_d = 1'b0;
            if (state_q == PLAY && gap_q != '0) state_d = GAP;
            else if (!empty)                    state_d = LOAD;
            else                                state_d = IDLE;
          end else if (tick) begin
            tcnt_d = tcnt_q + DUR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dur_stage_q <= '0;
      gap_q       <= '0;
      dur_cur_q   <= '0;
      tcnt_q      <= '0;
      div_q       <= '0;
      focw_q      <= '0;
      played_q    <= '0;
      run_q       <= 1'b0;
      ovf_q       <= 1'b0;
      gate_q      <= 1'b0;
      env_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dur_stage_q <= dur_stage_d;
      gap_q       <= gap_d;
      dur_cur_q   <= dur_cur_d;
      tcnt_q      <= tcnt_d;
      div_q       <= div_d;
      focw_q      <= focw_d;
      played_q    <= played_d;
      run_q       <= run_d;
      ovf_q       <= ovf_d;
      gate_q      <= gate_d;
      env_q       <= env_d;
      busy_q      <= busy_d;
    end
  end

  // Register read mux
  always_comb begin
    case (addr)
      5'd0:    rd_data = {16'b0, ovf_q, full, empty, 5'(count_q), 3'b0, state_q, run_q, gate_q, busy_q};
      5'd1:    rd_data = played_q;
      5'd4:    rd_data = {29'b0, loop_q, 1'b0, run_q};
      default: rd_data = '0;
    endcase
  end

  assign focw_out  = focw_q;
  assign env_start = env_q;
  assign gate      = gate_q;
  assign busy      = busy_q;
endmodule
